flowled_ctrl: RTL and testbench

FLOWLED_CTRL -- requirements
Module: flowled_ctrl

---
 rtl/flowled_ctrl_if.sv | 22 ++
 rtl/flowled_ctrl.sv | 150 +++++++++++++++
 tb/tb_flowled_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/flowled_ctrl_if.sv
// Signal bundle between the two push-buttons, the flowled pattern engine and flowled_ctrl.
// The controller takes the slave view; the board/bench side takes the master view.
interface flowled_ctrl_if;
    logic key_run;
    logic key_rst;
    logic start;
    logic pat_reset;

    modport master (
        output key_run,
        output key_rst,
        input  start,
        input  pat_reset
    );

    modport slave (
        input  key_run,
        input  key_rst,
        output start,
        output pat_reset
    );
endinterface

// File: rtl/flowled_ctrl.sv
// Run/pause and pattern-reset controller for flowled: synchronises and debounces two
// bouncing push-buttons, toggles the run enable and stretches pattern-reset pulses.
module flowled_ctrl #(
    parameter int unsigned DEB_CYCLES  = 1000000,
    parameter int unsigned HOLD_CYCLES = 2097152
) (
    input  logic           clk,
    input  logic           reset,
    flowled_ctrl_if.slave  io_ctl
);

    localparam int CNT_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    localparam int KEY_RUN = 0;
    localparam int KEY_RST = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_P_WAIT = 2'd1,
        ST_HELD   = 2'd2,
        ST_R_WAIT = 2'd3
    } deb_state_e;

    logic [1:0]        w_key_raw;
    logic [1:0]        r_sync1;
    logic [1:0]        r_sync2;
    logic [1:0]        w_press_evt;
    logic              w_run_evt;
    logic              w_rst_evt;
    logic              r_start;
    logic              r_pat_reset;
    logic [HOLD_W-1:0] r_hold;

    assign w_key_raw = {io_ctl.key_rst, io_ctl.key_run};

    // Two-flop synchronisers; only the second stage feeds any logic.
    // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_key_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_deb
        deb_state_e       r_state;
        deb_state_e       w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             w_sync;
        logic             w_press;

        assign w_sync = r_sync2[g];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_sync) begin
                        w_state_nxt = ST_P_WAIT;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_P_WAIT: begin
                    if (!w_sync) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_HELD;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!w_sync) begin
                        w_state_nxt = ST_R_WAIT;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_R_WAIT: begin
                    if (w_sync) begin
                        w_state_nxt = ST_HELD;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        // Press event is Mealy so it acts on the same edge that enters HELD.
        always_comb begin
            w_press = (r_state == ST_P_WAIT) && w_sync && (r_cnt == CNT_LAST);
        end

        assign w_press_evt[g] = w_press;
    end

    assign w_run_evt = w_press_evt[KEY_RUN];
    assign w_rst_evt = w_press_evt[KEY_RST];

    // A reset press always wins over a simultaneous run press and retriggers the hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_start     <= 1'b0;
            r_pat_reset <= 1'b1;
            r_hold      <= HOLD_LOAD;
        end else if (w_rst_evt) begin
            r_start     <= 1'b0;
            r_pat_reset <= 1'b1;
            r_hold      <= HOLD_LOAD;
        end else begin
            if (w_run_evt) begin
                r_start <= ~r_start;
            end
            if (r_hold != '0) begin
                r_hold      <= r_hold - 1'b1;
                r_pat_reset <= (r_hold != HOLD_W'(1));
            end else begin
                r_pat_reset <= 1'b0;
            end
        end
    end

    assign io_ctl.start     = r_start;
    assign io_ctl.pat_reset = r_pat_reset;

endmodule

// File: tb/tb_flowled_ctrl.sv
// Bench for flowled_ctrl: directed button scenarios plus random bouncing, scored against a
// stable-time reference model through an expectation queue drained by a separate monitor.
module tb_flowled_ctrl;

    localparam int DEB  = 4;
    localparam int HOLD = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    flowled_ctrl_if bus ();

    flowled_ctrl #(
        .DEB_CYCLES  (DEB),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .io_ctl (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic start;
        logic pat;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a key's accepted level flips after DEB+1 consecutive synchronised
    // samples disagreeing with it; pat_reset is simply "hold time remaining".
    bit m_q1[2];
    bit m_q2[2];
    bit m_lvl[2];
    int m_run[2];
    bit m_start;
    int m_hold;

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_q1[k]  = 1'b0;
            m_q2[k]  = 1'b0;
            m_lvl[k] = 1'b0;
            m_run[k] = 0;
        end
        m_start = 1'b0;
        m_hold  = HOLD;
    endfunction

    always @(negedge reset) begin
        model_reset();
        if (sb_q.size() > 0) sb_q[sb_q.size()-1] = '{start: 1'b0, pat: 1'b1};
    end

    always @(posedge clk) begin
        bit raw[2];
        bit press[2];
        bit samp;
        if (!reset) begin
            model_reset();
        end else begin
            raw[0] = bus.key_run;
            raw[1] = bus.key_rst;
            for (int k = 0; k < 2; k++) begin
                samp     = m_q2[k];
                m_q2[k]  = m_q1[k];
                m_q1[k]  = raw[k];
                press[k] = 1'b0;
                if (samp != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DEB + 1) begin
                        m_lvl[k] = samp;
                        m_run[k] = 0;
                        press[k] = samp;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            if (press[1]) begin
                m_hold  = HOLD;
                m_start = 1'b0;
            end else begin
                if (press[0]) m_start = !m_start;
                if (m_hold > 0) m_hold--;
            end
        end
        sb_q.push_back('{start: m_start, pat: (m_hold != 0)});
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("start", {31'd0, bus.start}, {31'd0, e.start});
            check("pat_reset", {31'd0, bus.pat_reset}, {31'd0, e.pat});
        end
    end

    task automatic hold_for(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic measure_pat_clear(input string name);
        int e;
        e = 0;
        for (int i = 1; i <= 3 * HOLD && e == 0; i++) begin
            @(posedge clk);
            #1;
            if (bus.pat_reset === 1'b0) e = i;
        end
        #1;
        check(name, e, HOLD);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e;
        bus.key_run = 1'b0;
        bus.key_rst = 1'b0;
        #1 reset = 1'b0;
        @(posedge clk);
        #2;
        hold_for(2);

        // Power-up: pattern reset held for exactly HOLD cycles after release.
        reset = 1'b1;
        measure_pat_clear("pat_clear_after_reset");
        hold_for(4);

        // Clean run press: start toggles DEB+3 edges after the rise, once.
        bus.key_run = 1'b1;
        e = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.start === 1'b1 && e == 0) e = i;
        end
        #1;
        check("run_press_edge", e, DEB + 3);
        bus.key_run = 1'b0;
        hold_for(10);
        bus.key_run = 1'b1;
        hold_for(20);
        bus.key_run = 1'b0;
        hold_for(10);

        // Bounce shorter than the debounce window.
        repeat (8) begin
            bus.key_run = 1'b1;
            hold_for(3);
            bus.key_run = 1'b0;
            hold_for(1);
        end
        hold_for(8);

        // Run, then pattern reset with a retrigger.
        bus.key_run = 1'b1;
        hold_for(10);
        bus.key_run = 1'b0;
        hold_for(10);
        bus.key_rst = 1'b1;
        hold_for(8);
        bus.key_rst = 1'b0;
        hold_for(7);
        bus.key_rst = 1'b1;
        hold_for(10);
        bus.key_rst = 1'b0;
        hold_for(20);

        // Both keys rise together: reset wins.
        bus.key_run = 1'b1;
        bus.key_rst = 1'b1;
        hold_for(10);
        bus.key_run = 1'b0;
        bus.key_rst = 1'b0;
        hold_for(20);

        // Run press landing inside an active hold still toggles start.
        bus.key_rst = 1'b1;
        hold_for(6);
        bus.key_run = 1'b1;
        hold_for(10);
        bus.key_run = 1'b0;
        bus.key_rst = 1'b0;
        hold_for(20);

        // Reset in the middle of a run debounce abandons it.
        bus.key_run = 1'b1;
        hold_for(4);
        reset = 1'b0;
        bus.key_run = 1'b0;
        hold_for(2);
        reset = 1'b1;
        measure_pat_clear("pat_clear_after_midreset");
        hold_for(10);

        // Random bouncing on both keys with occasional resets.
        for (int s = 0; s < 600; s++) begin
            bus.key_run = 1'($urandom_range(0, 1));
            bus.key_rst = ($urandom_range(0, 3) == 0);
            hold_for($urandom_range(1, 12));
            if ($urandom_range(0, 60) == 0) begin
                reset = 1'b0;
                hold_for($urandom_range(1, 3));
                reset = 1'b1;
            end
        end
        bus.key_run = 1'b0;
        bus.key_rst = 1'b0;
        hold_for(30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
